// File: rtl/tdm_demux2_pkg.sv
// Shared definitions for the two-slot TDM demultiplexer: default widths and
// frame-alignment state encodings.
`default_nettype none

package tdm_demux2_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = 4;

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    EXP_A = 2'b01,
    EXP_B = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tdm_demux2_slot_reg.sv
// slot_reg: WIDTH-bit load-enabled capture register with asynchronous
// active-low clear, one per demultiplexed slot.
`default_nettype none

module slot_reg
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux2.sv
// tdm_demux2: splits an alternating A/B slot stream into two registered
// channels, tracks frame alignment from SYNC and counts framing violations.
`default_nettype none

module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             a_valid,
  output logic             b_valid,
  output logic             pair_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  state_t state;
  state_t state_nx;
  logic   cap_a;
  logic   cap_b;
  logic   frame_err;
  logic   locked_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (din_valid) begin
      case (state)
        HUNT:    state_nx = sync ? EXP_B : HUNT;
        EXP_A:   state_nx = sync ? EXP_B : HUNT;
        EXP_B:   state_nx = sync ? EXP_B : EXP_A;
        default: state_nx = HUNT;
      endcase
    end
  end

  // Lock is only earned once a full A/B pair has been seen; an early frame
  // inside EXP_B keeps whatever lock status the frame already had.
  always_comb begin
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    frame_err = 1'b0;
    locked_nx = locked;
    if (din_valid) begin
      case (state)
        HUNT: begin
          cap_a     = sync;
          locked_nx = 1'b0;
        end
        EXP_A: begin
          cap_a     = sync;
          frame_err = !sync;
          locked_nx = sync;
        end
        EXP_B: begin
          cap_a     = sync;
          cap_b     = !sync;
          frame_err = sync;
          locked_nx = sync ? locked : 1'b1;
        end
        default: begin
          locked_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      pair_valid <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      a_valid    <= cap_a;
      b_valid    <= cap_b;
      pair_valid <= cap_b;
      sync_err   <= frame_err;
      locked     <= locked_nx;
      if (frame_err && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  slot_reg #(.WIDTH(WIDTH)) u_slot_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cap_a),
    .d     (din),
    .q     (out_a)
  );

  slot_reg #(.WIDTH(WIDTH)) u_slot_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cap_b),
    .d     (din),
    .q     (out_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2: expected pulse events are queued at
// stimulus time and popped by a monitor whenever the DUT pulses an output.
`default_nettype none

module tb_tdm_demux2;
  import tdm_demux2_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int EW = DEF_ERR_W;

  typedef struct packed {
    logic          av;
    logic          bv;
    logic          pv;
    logic          se;
    logic [W-1:0]  oa;
    logic [W-1:0]  ob;
    logic          lk;
    logic [EW-1:0] ec;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          sync;
  logic [W-1:0]  out_a;
  logic [W-1:0]  out_b;
  logic          a_valid;
  logic          b_valid;
  logic          pair_valid;
  logic          locked;
  logic          sync_err;
  logic [EW-1:0] err_cnt;

  int  checks   = 0;
  int  failures = 0;
  ev_t exp_q[$];

  tdm_demux2 #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .out_a      (out_a),
    .out_b      (out_b),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .pair_valid (pair_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic av, input logic bv, input logic pv, input logic se,
                      input logic [W-1:0] oa, input logic [W-1:0] ob,
                      input logic lk, input logic [EW-1:0] ec);
    ev_t e;
    e = '{av: av, bv: bv, pv: pv, se: se, oa: oa, ob: ob, lk: lk, ec: ec};
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; presents one word for exactly one rising edge.
  task automatic send(input logic [W-1:0] d, input logic s);
    din       = d;
    sync      = s;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  // Monitor: every pulse cycle must match the oldest queued expectation.
  initial begin
    ev_t e;
    ev_t act;
    forever begin
      @(negedge clk);
      if (rst_n && (a_valid || b_valid || pair_valid || sync_err)) begin
        act = '{av: a_valid, bv: b_valid, pv: pair_valid, se: sync_err,
                oa: out_a, ob: out_b, lk: locked, ec: err_cnt};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got av=%b bv=%b pv=%b se=%b oa=%h ob=%h lk=%b ec=%0d, expected no pulse",
                   act.av, act.bv, act.pv, act.se, act.oa, act.ob, act.lk, act.ec);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL event: got av=%b bv=%b pv=%b se=%b oa=%h ob=%h lk=%b ec=%0d, expected av=%b bv=%b pv=%b se=%b oa=%h ob=%h lk=%b ec=%0d",
                     act.av, act.bv, act.pv, act.se, act.oa, act.ob, act.lk, act.ec,
                     e.av, e.bv, e.pv, e.se, e.oa, e.ob, e.lk, e.ec);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]  oa;
    logic [W-1:0]  ob;
    logic [EW-1:0] ec;

    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_a",   32'(out_a), 32'h0);
    chk("rst_out_b",   32'(out_b), 32'h0);
    chk("rst_pulses",  32'({a_valid, b_valid, pair_valid, sync_err}), 32'h0);
    chk("rst_locked",  32'(locked), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-frame demux; lock appears with the first completed pair.
    push(1, 0, 0, 0, 8'h11, 8'h00, 0, 0); send(8'h11, 1);
    push(0, 1, 1, 0, 8'h11, 8'h22, 1, 0); send(8'h22, 0);
    push(1, 0, 0, 0, 8'h33, 8'h22, 1, 0); send(8'h33, 1);
    push(0, 1, 1, 0, 8'h33, 8'h44, 1, 0); send(8'h44, 0);
    chk("locked_after_pairs", 32'(locked), 32'h1);

    // Missing sync while locked in EXP_A: error, back to HUNT.
    push(0, 0, 0, 1, 8'h33, 8'h44, 0, 1); send(8'h77, 0);
    chk("unlock_after_miss", 32'(locked), 32'h0);

    // In HUNT a non-sync word is dropped silently.
    send(8'h55, 0);
    chk("hunt_drop_out_a",   32'(out_a), 32'h33);
    chk("hunt_drop_err_cnt", 32'(err_cnt), 32'h1);
    push(1, 0, 0, 0, 8'h66, 8'h44, 0, 1); send(8'h66, 1);

    // Early frames while waiting for B replace A and flag an error each.
    push(1, 0, 0, 1, 8'h10, 8'h44, 0, 2); send(8'h10, 1);
    push(1, 0, 0, 1, 8'h20, 8'h44, 0, 3); send(8'h20, 1);
    push(0, 1, 1, 0, 8'h20, 8'h30, 1, 3); send(8'h30, 0);

    // Repeated violations drive the counter to saturation.
    oa = 8'h20;
    ob = 8'h30;
    ec = 4'd3;
    for (int i = 0; i < 20; i++) begin
      ec = (ec == 4'd15) ? 4'd15 : ec + 4'd1;
      push(0, 0, 0, 1, oa, ob, 0, ec); send(8'h70 + W'(i), 0);
      oa = 8'hA0 + W'(i);
      push(1, 0, 0, 0, oa, ob, 0, ec); send(oa, 1);
      ob = 8'hB0 + W'(i);
      push(0, 1, 1, 0, oa, ob, 1, ec); send(ob, 0);
    end
    chk("err_cnt_saturated", 32'(err_cnt), 32'd15);

    // Reset between A and B: partial pair discarded, first word after dropped.
    push(1, 0, 0, 0, 8'h12, 8'hC3, 1, 15); send(8'h12, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_a",   32'(out_a), 32'h0);
    chk("mid_rst_out_b",   32'(out_b), 32'h0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("mid_rst_locked",  32'(locked), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h99, 0);
    chk("post_rst_out_a",  32'(out_a), 32'h0);
    chk("post_rst_out_b",  32'(out_b), 32'h0);
    chk("post_rst_pulses", 32'({a_valid, b_valid, pair_valid, sync_err}), 32'h0);
    chk("post_rst_locked", 32'(locked), 32'h0);
    send(8'h5A, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
